// File: rtl/hazard_alert_ctrl.sv
// rtl/hazard_alert_ctrl.sv - per-channel hazard persistence/latch FSMs driving alert LEDs
module hazard_alert_ctrl #(
    parameter int NCH     = 4,
    parameter int SW      = 2,
    parameter int PERSIST = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic [NCH*SW-1:0]          sev,
    input  logic [NCH*SW-1:0]          thr,
    input  logic                       mode,
    input  logic [NCH-1:0]             ack,
    input  logic                       clear_all,
    output logic [NCH-1:0]             led,
    output logic                       alarm_any,
    output logic [$clog2(NCH+1)-1:0]   alarm_cnt
);

    localparam int CW = $clog2(PERSIST + 1);
    localparam int AW = $clog2(NCH + 1);
    localparam logic [CW-1:0] PERSIST_C = CW'(PERSIST);

    typedef enum logic [1:0] {IDLE, PENDING, ALARM, ACKED} ch_state_t;

    ch_state_t     state   [NCH];
    ch_state_t     state_n [NCH];
    logic [CW-1:0] cnt     [NCH];
    logic [CW-1:0] cnt_n   [NCH];
    logic [NCH-1:0] hit;
    logic [NCH-1:0] alarm_n;
    logic [NCH-1:0] led_n;
    logic [AW-1:0]  alarm_cnt_n;

    // Per-channel hit: a zero threshold disables the channel
    always_comb begin
        hit = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i] = (thr[i*SW +: SW] != '0) && (sev[i*SW +: SW] >= thr[i*SW +: SW]);
        end
    end

    // Next-state and persistence counter for every channel; clear_all wins over everything
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_n[i] = state[i];
            cnt_n[i]   = cnt[i];
            if (clear_all) begin
                state_n[i] = IDLE;
                cnt_n[i]   = '0;
            end else begin
                case (state[i])
                    IDLE: begin
                        if (sample_en && hit[i]) begin
                            cnt_n[i]   = CW'(1);
                            state_n[i] = (PERSIST == 1) ? ALARM : PENDING;
                        end
                    end
                    PENDING: begin
                        if (sample_en) begin
                            if (hit[i]) begin
                                cnt_n[i] = cnt[i] + CW'(1);
                                if (cnt[i] + CW'(1) == PERSIST_C) begin
                                    state_n[i] = ALARM;
                                end
                            end else begin
                                cnt_n[i]   = '0;
                                state_n[i] = IDLE;
                            end
                        end
                    end
                    // ack only sees channels already latched before this edge
                    ALARM: begin
                        if (ack[i]) begin
                            state_n[i] = ACKED;
                        end
                    end
                    // stay silenced until the hazard condition actually clears
                    ACKED: begin
                        if (sample_en && !hit[i]) begin
                            state_n[i] = IDLE;
                            cnt_n[i]   = '0;
                        end
                    end
                    default: begin
                        state_n[i] = IDLE;
                        cnt_n[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Output values derived from next state so led rises on the ALARM entry edge
    always_comb begin
        alarm_cnt_n = '0;
        for (int i = 0; i < NCH; i++) begin
            alarm_n[i] = (state_n[i] == ALARM);
            if (alarm_n[i]) begin
                alarm_cnt_n = alarm_cnt_n + AW'(1);
            end
        end
        // priority mode isolates the lowest-index alarm bit
        led_n = mode ? alarm_n : (alarm_n & (~alarm_n + NCH'(1)));
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state[i] <= state_n[i];
                cnt[i]   <= cnt_n[i];
            end
        end
    end

    // Registered indicator outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led       <= '0;
            alarm_any <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            led       <= led_n;
            alarm_any <= |alarm_n;
            alarm_cnt <= alarm_cnt_n;
        end
    end

endmodule

// File: tb/tb_hazard_alert_ctrl.sv
// tb/tb_hazard_alert_ctrl.sv - scoreboard bench for hazard_alert_ctrl
module tb_hazard_alert_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_en;
    logic [7:0] sev;
    logic [7:0] thr;
    logic       mode;
    logic [3:0] ack;
    logic       clear_all;
    logic [3:0] led;
    logic       alarm_any;
    logic [2:0] alarm_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];

    // reference model: 0 idle, 1 pending, 2 alarm, 3 acked
    int m_st [4];
    int m_cn [4];

    hazard_alert_ctrl #(.NCH(4), .SW(2), .PERSIST(3)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .sev(sev), .thr(thr),
        .mode(mode), .ack(ack), .clear_all(clear_all),
        .led(led), .alarm_any(alarm_any), .alarm_cnt(alarm_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0;
            m_cn[i] = 0;
        end
    endtask

    // drive one cycle, advance the model, queue expected and observed outputs
    task automatic step(input logic se, input logic [3:0] ak, input logic clr);
        logic [3:0] al;
        logic [3:0] eled;
        int n;
        bit h;
        sample_en = se;
        ack = ak;
        clear_all = clr;
        for (int i = 0; i < 4; i++) begin
            h = (thr[i*2 +: 2] != 2'd0) && (sev[i*2 +: 2] >= thr[i*2 +: 2]);
            if (clr) begin
                m_st[i] = 0; m_cn[i] = 0;
            end else if (m_st[i] == 0) begin
                if (se && h) begin m_cn[i] = 1; m_st[i] = 1; end
            end else if (m_st[i] == 1) begin
                if (se && h) begin
                    m_cn[i]++;
                    if (m_cn[i] == 3) m_st[i] = 2;
                end else if (se) begin
                    m_cn[i] = 0; m_st[i] = 0;
                end
            end else if (m_st[i] == 2) begin
                if (ak[i]) m_st[i] = 3;
            end else begin
                if (se && !h) begin m_st[i] = 0; m_cn[i] = 0; end
            end
        end
        n = 0;
        eled = 4'b0;
        for (int i = 0; i < 4; i++) begin
            al[i] = (m_st[i] == 2);
            if (al[i]) n++;
        end
        if (mode) eled = al;
        else begin
            for (int i = 3; i >= 0; i--) if (al[i]) eled = 4'b0001 << i;
        end
        exp_q.push_back({eled, |al, 3'(n)});
        @(posedge clk);
        #1;
        obs_q.push_back({led, alarm_any, alarm_cnt});
        sample_en = 1'b0;
        ack = 4'b0;
        clear_all = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({led, alarm_any, alarm_cnt} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs got %b exp %b", {led, alarm_any, alarm_cnt}, 8'h00);
        end
    endtask

    task automatic test_persist();
        logic [7:0] e, o;
        mode = 1'b0; thr = 8'b00_00_10_00; sev = 8'b00_00_11_00;
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
        vectors++;
        if (led !== 4'b0000) begin miscompares++; $display("FAIL persist_early got %b exp 0000", led); end
        step(1, 0, 0);
        vectors++;
        if (led !== 4'b0010) begin miscompares++; $display("FAIL persist_led got %b exp 0010", led); end
        vectors++;
        if (alarm_cnt !== 3'd1) begin miscompares++; $display("FAIL persist_cnt got %0d exp 1", alarm_cnt); end
        step(0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL persist_sb got %b exp %b", o, e); end
        end
    endtask

    task automatic test_restart();
        logic [7:0] e, o;
        thr = 8'b00_00_10_00; sev = 8'b00_00_11_00;
        step(1, 0, 0); step(1, 0, 0);
        sev = 8'b00_00_01_00;
        step(1, 0, 0);
        sev = 8'b00_00_11_00;
        step(1, 0, 0); step(1, 0, 0);
        vectors++;
        if (led !== 4'b0000) begin miscompares++; $display("FAIL restart_early got %b exp 0000", led); end
        step(1, 0, 0);
        vectors++;
        if (led !== 4'b0010) begin miscompares++; $display("FAIL restart_led got %b exp 0010", led); end
        step(0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL restart_sb got %b exp %b", o, e); end
        end
    endtask

    task automatic test_modes();
        logic [7:0] e, o;
        mode = 1'b0; thr = 8'b00_01_00_01; sev = 8'b00_11_00_11;
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        vectors++;
        if ({led, alarm_cnt} !== {4'b0001, 3'd2}) begin
            miscompares++; $display("FAIL mode_prio got led %b cnt %0d exp 0001/2", led, alarm_cnt);
        end
        mode = 1'b1;
        step(0, 0, 0);
        vectors++;
        if ({led, alarm_cnt} !== {4'b0101, 3'd2}) begin
            miscompares++; $display("FAIL mode_multi got led %b cnt %0d exp 0101/2", led, alarm_cnt);
        end
        mode = 1'b0;
        step(0, 0, 0);
        step(0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL modes_sb got %b exp %b", o, e); end
        end
    endtask

    task automatic test_ack();
        logic [7:0] e, o;
        mode = 1'b1; thr = 8'b00_10_00_00; sev = 8'b00_11_00_00;
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        step(0, 4'b0100, 0);
        step(1, 0, 0); step(1, 0, 0);
        vectors++;
        if ({led, alarm_any} !== 5'b0) begin miscompares++; $display("FAIL ack_silenced got %b exp 00000", {led, alarm_any}); end
        sev = 8'b00_00_00_00;
        step(1, 0, 0);
        sev = 8'b00_11_00_00;
        step(1, 0, 0); step(1, 0, 0);
        step(1, 0, 0);
        vectors++;
        if (led !== 4'b0100) begin miscompares++; $display("FAIL ack_realarm got %b exp 0100", led); end
        step(0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL ack_sb got %b exp %b", o, e); end
        end
    endtask

    task automatic test_edges();
        logic [7:0] e, o;
        mode = 1'b1; thr = 8'h00; sev = 8'hFF;
        for (int k = 0; k < 10; k++) step(1, 0, 0);
        vectors++;
        if (led !== 4'b0000) begin miscompares++; $display("FAIL thr_zero got %b exp 0000", led); end
        thr = 8'b00_00_00_01; sev = 8'b00_00_00_11;
        step(1, 0, 0); step(1, 0, 0); step(1, 4'b0001, 0);
        step(0, 0, 0);
        vectors++;
        if (led !== 4'b0001) begin miscompares++; $display("FAIL ack_entry got %b exp 0001", led); end
        step(0, 0, 1);
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);
        vectors++;
        if (led !== 4'b0000) begin miscompares++; $display("FAIL clear_hit got %b exp 0000", led); end
        step(1, 0, 0);
        step(0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL edges_sb got %b exp %b", o, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e, o;
        mode = 1'b1; thr = 8'b00_00_01_01; sev = 8'b00_00_11_11;
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL areset_pre_sb got %b exp %b", o, e); end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({led, alarm_any, alarm_cnt} !== 8'h00) begin
            miscompares++; $display("FAIL async_reset got %b exp 00000000", {led, alarm_any, alarm_cnt});
        end
        model_reset();
        #2 rst_n = 1'b1;
        step(1, 0, 0); step(1, 0, 0);
        vectors++;
        if (led !== 4'b0000) begin miscompares++; $display("FAIL areset_early got %b exp 0000", led); end
        step(1, 0, 0);
        vectors++;
        if (led !== 4'b0011) begin miscompares++; $display("FAIL areset_realarm got %b exp 0011", led); end
        step(0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL areset_sb got %b exp %b", o, e); end
        end
    endtask

    task automatic test_random();
        logic [7:0] e, o;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) thr = 8'($urandom);
            sev = 8'($urandom);
            mode = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0,
                 $urandom_range(0, 40) == 0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL random_sb got %b exp %b", o, e); end
        end
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b0; sev = 8'h00; thr = 8'h00;
        mode = 1'b0; ack = 4'b0; clear_all = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_persist();
        test_restart();
        test_modes();
        test_ack();
        test_edges();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_alert_ctrl.md
Name: hazard_alert_ctrl

Overview:
Parametrised, clocked successor to the combinational disaster-detection block. It watches NCH hazard channels, each carrying an SW-bit severity, and compares each against a runtime threshold. A channel raises an alarm only after the hit persists for PERSIST consecutive sample strobes; the alarm then stays latched until the operator acknowledges it. It feeds the board alert LEDs and buzzer logic, with the same priority/multi display modes as before.

Parameters:
NCH, 4, number of hazard channels (index 0 = highest priority)
SW, 2, severity and threshold width per channel, in bits
PERSIST, 3, consecutive qualifying samples required to alarm (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
sample_en  in  1  one-cycle strobe; severities are evaluated only when high
sev  in  NCH*SW  channel i severity at bits [i*SW +: SW], unsigned
thr  in  NCH*SW  channel i threshold, same packing; 0 = channel disabled
mode  in  1  0 = priority display, 1 = multi display
ack  in  NCH  per-channel acknowledge pulse
clear_all  in  1  synchronous clear of all channels
led  out  NCH  alarm indicators
alarm_any  out  1  OR of all channels in ALARM state (independent of mode)
alarm_cnt  out  $clog2(NCH+1)  number of channels in ALARM state

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset: all channels go to IDLE with cnt=0. led=0, alarm_any=0, alarm_cnt=0.
- Hit definition: hit[i] = (thr[i]!=0) && (sev[i] >= thr[i]), unsigned compare. A threshold of 0 never hits.
- Each channel has its own FSM and a persistence counter wide enough to hold PERSIST.
  - IDLE: on sample_en&&hit, set cnt=1 and go to ALARM if PERSIST==1, otherwise to PENDING.
  - PENDING: on sample_en&&hit, increment cnt; when cnt+1==PERSIST, go to ALARM. On sample_en&&!hit, set cnt=0 and go to IDLE. With no sample_en, hold state.
  - ALARM: latched, and ignores sev. If ack[i]=1, go to ACKED.
  - ACKED: alarm silenced. On sample_en&&!hit, go to IDLE with cnt=0. On sample_en&&hit, stay in ACKED (no re-alarm until the condition clears).
- clear_all: on the next edge, all channels go to IDLE with cnt=0. This takes priority over sample_en and ack.
- ack rules: ack acts only on a channel that is already in ALARM before the edge. An ack arriving on the same edge the channel enters ALARM is ignored. An ack in any other state is a no-op.
- Outputs are registered and computed from next-state values, so led rises on the same edge the channel enters ALARM.
  - mode=1: led[i] = (state[i]==ALARM).
  - mode=0: only the lowest-index channel in ALARM is lit; all other led bits are 0.
  - alarm_any and alarm_cnt count ALARM states only, irrespective of mode.
- A mode change is reflected in led at the next edge; it has no effect on channel states.
- sev and thr changes between strobes are ignored. Values are sampled only when sample_en=1.
- Counter saturation is not needed: the counter never exceeds PERSIST because ALARM exits the counting path.
- If rst_n is asserted mid-PENDING, all progress is discarded immediately (asynchronous).

Test Plan:
1. NCH=4, SW=2, PERSIST=3; ch1 thr=2, sev=3; issue 3 sample_en strobes -> led=4'b0010 rises on the edge of the 3rd strobe; alarm_cnt=1.
2. Two hits on ch1, then a strobe with sev=1 -> ch1 returns to IDLE, led stays 0. Three more hits -> alarm raised (counter restarted from 0).
3. ch0 and ch2 in ALARM. mode=0 -> led=4'b0001; switch to mode=1 -> led=4'b0101 next cycle; alarm_cnt=2 in both modes.
4. ch2 in ALARM, pulse ack[2] while sev stays above thr -> led[2]=0, ACKED held across hitting strobes. One non-hit strobe and then 3 hits -> alarm again.
5. ch3 thr=0, sev=3 for 10 strobes -> never alarms. Separately, ack on the entry edge is ignored (led stays 1). clear_all concurrent with the 3rd hit -> IDLE, led=0.
6. rst_n low asynchronously mid-cycle with 2 channels in ALARM -> all outputs 0 immediately. After release, 3 hits are needed again to alarm.
